gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises the two-input multiple-gate unit (NOT_A, OR, AND, NOR, NAND, XOR, XNOR).
- Drives all four input vectors to an external gate instance and waits a programmable settle time per vector.
- Samples the seven gate outputs and checks them against a golden truth table.
- Reports a pass flag plus per-gate and per-vector failure masks.
- Sits beside the gate unit as its built-in self-test controller.

---
 rtl/gate_sweep_pkg.sv | 41 ++++
 rtl/gate_sweep_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types, constants and the golden truth table for the gate sweep controller.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_GATES   = 7;
  localparam int N_VECTORS = 4;

  // Bit positions of each gate inside gate_out / fail_mask
  localparam int GATE_NOT_A = 0;
  localparam int GATE_OR    = 1;
  localparam int GATE_AND   = 2;
  localparam int GATE_NOR   = 3;
  localparam int GATE_NAND  = 4;
  localparam int GATE_XOR   = 5;
  localparam int GATE_XNOR  = 6;

  // Expected gate unit outputs for input vector {A,B}
  function automatic logic [N_GATES-1:0] golden(input logic [1:0] vec);
    logic a;
    logic b;
    logic [N_GATES-1:0] g;
    a = vec[1];
    b = vec[0];
    g = '0;
    g[GATE_NOT_A] = ~a;
    g[GATE_OR]    = a | b;
    g[GATE_AND]   = a & b;
    g[GATE_NOR]   = ~(a | b);
    g[GATE_NAND]  = ~(a & b);
    g[GATE_XOR]   = a ^ b;
    g[GATE_XNOR]  = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Built-in self-test sequencer for the two-input multiple-gate unit.
// Walks vectors 0..3, holds each for SETTLE_CYCLES cycles, then compares
// the seven gate outputs against the golden table and accumulates failures.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [1:0]           gate_in,
  input  logic [N_GATES-1:0]   gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic                 pass,
  output logic [N_GATES-1:0]   fail_mask,
  output logic [N_VECTORS-1:0] fail_vec
);

  // Counter reload: SETTLE counts down to zero, so the vector is held
  // for reload+1 = SETTLE_CYCLES cycles before CHECK.
  localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic [1:0]           r_gate_in;
  logic [1:0]           w_gate_in_next;
  logic                 r_busy;
  logic                 w_busy_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_result_valid;
  logic                 w_result_valid_next;
  logic                 r_pass;
  logic                 w_pass_next;
  logic [N_GATES-1:0]   r_fail_mask;
  logic [N_GATES-1:0]   w_fail_mask_next;
  logic [N_VECTORS-1:0] r_fail_vec;
  logic [N_VECTORS-1:0] w_fail_vec_next;

  logic [N_GATES-1:0]   w_err;
  logic [N_GATES-1:0]   w_fail_mask_upd;
  logic [N_VECTORS-1:0] w_vec_hit;

  assign w_err           = gate_out ^ golden(r_gate_in);
  assign w_fail_mask_upd = r_fail_mask | w_err;

  // One-hot per-vector mismatch flag for the vector currently under test
  genvar gi;
  generate
    for (gi = 0; gi < N_VECTORS; gi++) begin : g_vec_hit
      assign w_vec_hit[gi] = (r_gate_in == 2'(gi)) && (|w_err);
    end
  endgenerate

  // State and registered-output update; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_gate_in      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_pass         <= 1'b0;
      r_fail_mask    <= '0;
      r_fail_vec     <= '0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_gate_in      <= w_gate_in_next;
      r_busy         <= w_busy_next;
      r_done         <= w_done_next;
      r_result_valid <= w_result_valid_next;
      r_pass         <= w_pass_next;
      r_fail_mask    <= w_fail_mask_next;
      r_fail_vec     <= w_fail_vec_next;
    end
  end

  // Next-state decode; abort returns to IDLE from any active state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start && !abort) w_state_next = SETTLE;
      end
      SETTLE: begin
        if (abort)              w_state_next = IDLE;
        else if (r_cnt == 4'd0) w_state_next = CHECK;
      end
      CHECK: begin
        if (abort)                  w_state_next = IDLE;
        else if (r_gate_in == 2'd3) w_state_next = DONE;
        else                        w_state_next = SETTLE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and result masks.
  // The DONE-cycle outputs are produced on the edge leaving the last CHECK
  // so that done/result_valid/pass are visible during the DONE state.
  always_comb begin
    w_cnt_next          = r_cnt;
    w_gate_in_next      = r_gate_in;
    w_busy_next         = r_busy;
    w_done_next         = 1'b0;
    w_result_valid_next = r_result_valid;
    w_pass_next         = r_pass;
    w_fail_mask_next    = r_fail_mask;
    w_fail_vec_next     = r_fail_vec;
    case (r_state)
      IDLE: begin
        // abort together with start keeps the previous results intact
        if (start && !abort) begin
          w_gate_in_next      = 2'd0;
          w_cnt_next          = LP_RELOAD;
          w_busy_next         = 1'b1;
          w_result_valid_next = 1'b0;
          w_pass_next         = 1'b0;
          w_fail_mask_next    = '0;
          w_fail_vec_next     = '0;
        end
      end
      SETTLE: begin
        if (abort) begin
          w_busy_next    = 1'b0;
          w_gate_in_next = 2'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          // partial masks are left as-is; result_valid is already low
          w_busy_next    = 1'b0;
          w_gate_in_next = 2'd0;
        end else begin
          w_fail_mask_next = w_fail_mask_upd;
          w_fail_vec_next  = r_fail_vec | w_vec_hit;
          if (r_gate_in == 2'd3) begin
            w_done_next         = 1'b1;
            w_busy_next         = 1'b0;
            w_result_valid_next = 1'b1;
            w_pass_next         = (w_fail_mask_upd == '0);
          end else begin
            w_gate_in_next = r_gate_in + 2'd1;
            w_cnt_next     = LP_RELOAD;
          end
        end
      end
      DONE: begin
        w_busy_next    = 1'b0;
        w_gate_in_next = 2'd0;
      end
      default: begin
        w_busy_next    = 1'b0;
        w_gate_in_next = 2'd0;
      end
    endcase
  end

  assign gate_in      = r_gate_in;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;
  assign pass         = r_pass;
  assign fail_mask    = r_fail_mask;
  assign fail_vec     = r_fail_vec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: a behavioural gate unit (with an optional stuck-at-0 fault
// mask) sits beside the controller; a second controller is built with
// SETTLE_CYCLES=1 for the short-settle case.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] gate_in;
  logic [6:0] gate_out;
  logic       busy, done, result_valid, pass;
  logic [6:0] fail_mask;
  logic [3:0] fail_vec;
  logic [6:0] stuck0;

  logic       start2, abort2;
  logic [1:0] gate_in2;
  logic [6:0] gate_out2;
  logic       busy2, done2, result_valid2, pass2;
  logic [6:0] fail_mask2;
  logic [3:0] fail_vec2;

  int n_checks = 0;
  int n_errors = 0;
  int d;

  always #5 clk = ~clk;

  // Behavioural two-input multiple-gate unit
  function automatic logic [6:0] gate_unit(input logic [1:0] v);
    logic [6:0] o;
    o[0] = !v[1];
    o[1] = v[1] || v[0];
    o[2] = v[1] && v[0];
    o[3] = !(v[1] || v[0]);
    o[4] = !(v[1] && v[0]);
    o[5] = v[1] != v[0];
    o[6] = v[1] == v[0];
    return o;
  endfunction

  assign gate_out  = gate_unit(gate_in) & ~stuck0;
  assign gate_out2 = gate_unit(gate_in2);

  gate_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
    .result_valid(result_valid), .pass(pass),
    .fail_mask(fail_mask), .fail_vec(fail_vec)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .gate_in(gate_in2), .gate_out(gate_out2), .busy(busy2), .done(done2),
    .result_valid(result_valid2), .pass(pass2),
    .fail_mask(fail_mask2), .fail_vec(fail_vec2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then return in the cycle where done is seen (bounded)
  task automatic run_sweep(output int dcyc);
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    dcyc = c;
  endtask

  initial begin
    int c;
    logic seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stuck0 = 7'h00;
    start2 = 1'b0; abort2 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_gate_in", 32'(gate_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_mask", 32'(fail_mask), 0);
    chk("rst_vec", 32'(fail_vec), 0);

    // Correct unit: 3 cycles per vector, done in cycle 12
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t1_gate_in_c%0d", k), 32'(gate_in), 32'(k / 3));
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 1);
      chk($sformatf("t1_done_c%0d", k), 32'(done), 0);
      tick();
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_valid", 32'(result_valid), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_mask", 32'(fail_mask), 32'h00);
    chk("t1_vec", 32'(fail_vec), 32'h0);
    tick();
    chk("t1_done_c13", 32'(done), 0);
    chk("t1_gate_in_c13", 32'(gate_in), 0);
    chk("t1_valid_c13", 32'(result_valid), 1);

    // XOR stuck-at-0
    stuck0 = 7'b010_0000;
    run_sweep(d);
    chk("t2_latency", 32'(d), 12);
    chk("t2_pass", 32'(pass), 0);
    chk("t2_mask", 32'(fail_mask), 32'h20);
    chk("t2_vec", 32'(fail_vec), 32'b0110);
    chk("t2_valid", 32'(result_valid), 1);
    tick();
    stuck0 = 7'h00;

    // start+abort in IDLE: abort wins, old results stay
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t2b_busy", 32'(busy), 0);
    chk("t2b_valid", 32'(result_valid), 1);
    chk("t2b_mask", 32'(fail_mask), 32'h20);
    tick();
    chk("t2b_busy2", 32'(busy), 0);

    // abort in cycle 4
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_gate_in_c4", 32'(gate_in), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_busy_c5", 32'(busy), 0);
    chk("t3_gate_in_c5", 32'(gate_in), 0);
    chk("t3_valid_c5", 32'(result_valid), 0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    chk("t3_no_done", 32'(seen), 0);
    chk("t3_valid_end", 32'(result_valid), 0);

    // abort together with the final CHECK (cycle 11)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3b_done_c12", 32'(done), 0);
    chk("t3b_busy_c12", 32'(busy), 0);
    chk("t3b_valid_c12", 32'(result_valid), 0);
    chk("t3b_gate_in_c12", 32'(gate_in), 0);
    tick();
    chk("t3b_done_c13", 32'(done), 0);

    // start held high: done in cycles 12 and 26
    start = 1'b1;
    tick();
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    chk("t4_first_done", 32'(c), 12);
    tick(); c++;
    chk("t4_busy_c13", 32'(busy), 0);
    chk("t4_done_c13", 32'(done), 0);
    tick(); c++;
    chk("t4_busy_c14", 32'(busy), 1);
    chk("t4_gate_in_c14", 32'(gate_in), 0);
    while (done !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    start = 1'b0;
    chk("t4_second_done", 32'(c), 26);
    chk("t4_pass", 32'(pass), 1);
    tick(); tick();
    chk("t4_idle_busy", 32'(busy), 0);

    // rst in cycle 7 mid-sweep, then a clean sweep
    stuck0 = 7'b010_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("t5_partial_mask", 32'(fail_mask), 32'h20);
    chk("t5_partial_vec", 32'(fail_vec), 32'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_gate_in", 32'(gate_in), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_valid", 32'(result_valid), 0);
    chk("t5_rst_mask", 32'(fail_mask), 0);
    chk("t5_rst_vec", 32'(fail_vec), 0);
    stuck0 = 7'h00;
    run_sweep(d);
    chk("t5_latency", 32'(d), 12);
    chk("t5_pass", 32'(pass), 1);
    chk("t5_mask", 32'(fail_mask), 0);
    chk("t5_vec", 32'(fail_vec), 0);
    tick();

    // SETTLE_CYCLES=1 instance: 2 cycles per vector, done in cycle 8
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6_gate_in_c%0d", k), 32'(gate_in2), 32'(k / 2));
      chk($sformatf("t6_done_c%0d", k), 32'(done2), 0);
      tick();
    end
    chk("t6_done", 32'(done2), 1);
    chk("t6_pass", 32'(pass2), 1);
    chk("t6_valid", 32'(result_valid2), 1);
    chk("t6_mask", 32'(fail_mask2), 0);
    chk("t6_busy", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
